// File: rtl/player_action_ctrl.sv
// Button conditioning (sync, debounce, edge capture) and the player action FSM.
// Commands for the movement block are registered on SCEN frame ticks only.
module player_action_ctrl #(
  parameter int DEB_CYCLES     = 250000,
  parameter int DEB_WIDTH      = 18,
  parameter int CNT_WIDTH      = 8,
  parameter int ATTACK_FRAMES  = 6,
  parameter int RECOVER_FRAMES = 4,
  parameter int STUN_FRAMES    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_attack,
  input  logic       hit_taken,
  input  logic       jump_active,
  output logic       move_enable,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       attack_active,
  output logic       stun_active,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_ATTACK  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_STUN    = 3'd4
  } state_t;

  localparam int NBTN       = 4;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_ATTACK = 3;

  localparam logic [DEB_WIDTH-1:0] DEB_LAST     = DEB_WIDTH'(DEB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ATTACK_LAST  = CNT_WIDTH'(ATTACK_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] RECOVER_LAST = CNT_WIDTH'(RECOVER_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] STUN_LAST    = CNT_WIDTH'(STUN_FRAMES - 1);

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] deb_next;
  logic [NBTN-1:0] deb_rise;

  assign btn_raw = {btn_attack, btn_up, btn_right, btn_left};

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic                 sync1_reg;
      logic                 sync2_reg;
      logic                 level_reg;
      logic [DEB_WIDTH-1:0] cnt_reg;
      logic                 settle;

      // The debounced level flips on the clk where the counter has seen
      // DEB_CYCLES consecutive disagreeing samples.
      assign settle       = (sync2_reg != level_reg) && (cnt_reg == DEB_LAST);
      assign deb_next[gi] = settle ? sync2_reg : level_reg;
      assign deb_rise[gi] = settle & sync2_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (settle) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  logic deb_unused;
  assign deb_unused = &{1'b0, deb_next[BTN_ATTACK], deb_next[BTN_UP],
                        deb_rise[BTN_RIGHT], deb_rise[BTN_LEFT]};

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_inc;
  logic                 jump_pend_reg;
  logic                 atk_pend_reg;
  logic                 hit_pend_reg;

  logic jump_req;
  logic atk_req;
  logic hit_req;
  logic walk_l;
  logic walk_r;

  // An event arriving on the same clk as SCEN is consumed by that tick.
  assign jump_req = jump_pend_reg | deb_rise[BTN_UP];
  assign atk_req  = atk_pend_reg | deb_rise[BTN_ATTACK];
  assign hit_req  = hit_pend_reg | hit_taken;
  assign walk_l   = deb_next[BTN_LEFT] & ~deb_next[BTN_RIGHT];
  assign walk_r   = deb_next[BTN_RIGHT] & ~deb_next[BTN_LEFT];

  assign frame_cnt_inc = (&frame_cnt_reg) ? frame_cnt_reg : frame_cnt_reg + 1'b1;
  assign state         = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      frame_cnt_reg <= '0;
      jump_pend_reg <= 1'b0;
      atk_pend_reg  <= 1'b0;
      hit_pend_reg  <= 1'b0;
      move_enable   <= 1'b0;
      move_left     <= 1'b0;
      move_right    <= 1'b0;
      jump          <= 1'b0;
      attack_active <= 1'b0;
      stun_active   <= 1'b0;
    end else begin
      jump_pend_reg <= jump_pend_reg | deb_rise[BTN_UP];
      atk_pend_reg  <= atk_pend_reg | deb_rise[BTN_ATTACK];
      hit_pend_reg  <= hit_pend_reg | hit_taken;

      if (SCEN) begin
        jump          <= 1'b0;
        move_enable   <= 1'b0;
        move_left     <= 1'b0;
        move_right    <= 1'b0;
        attack_active <= 1'b0;
        stun_active   <= 1'b0;

        if (hit_req) begin
          // A hit pre-empts everything, restarting or aborting the current action.
          state_reg     <= ST_STUN;
          frame_cnt_reg <= '0;
          hit_pend_reg  <= 1'b0;
          atk_pend_reg  <= 1'b0;
          stun_active   <= 1'b1;
        end else begin
          case (state_reg)
            ST_STUN: begin
              if (frame_cnt_reg == STUN_LAST) begin
                state_reg     <= ST_IDLE;
                frame_cnt_reg <= '0;
                move_enable   <= 1'b1;
              end else begin
                frame_cnt_reg <= frame_cnt_inc;
                stun_active   <= 1'b1;
              end
            end

            ST_ATTACK: begin
              if (frame_cnt_reg == ATTACK_LAST) begin
                state_reg     <= ST_RECOVER;
                frame_cnt_reg <= '0;
              end else begin
                frame_cnt_reg <= frame_cnt_inc;
                attack_active <= 1'b1;
              end
            end

            ST_RECOVER: begin
              if (frame_cnt_reg == RECOVER_LAST) begin
                state_reg     <= ST_IDLE;
                frame_cnt_reg <= '0;
                move_enable   <= 1'b1;
              end else begin
                frame_cnt_reg <= frame_cnt_inc;
              end
            end

            default: begin
              // Requests are consumed here even when discarded (airborne).
              atk_pend_reg  <= 1'b0;
              jump_pend_reg <= 1'b0;
              jump          <= jump_req & ~jump_active;
              frame_cnt_reg <= '0;
              if (atk_req && !jump_active) begin
                state_reg     <= ST_ATTACK;
                attack_active <= 1'b1;
              end else begin
                state_reg   <= (walk_l | walk_r) ? ST_WALK : ST_IDLE;
                move_enable <= 1'b1;
                move_left   <= walk_l;
                move_right  <= walk_r;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Scoreboard bench for player_action_ctrl: stimulus queues expected outputs per
// frame tick, a monitor compares them as each SCEN tick (or reset) presents outputs.
module tb_player_action_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCEN;
  logic       btn_left, btn_right, btn_up, btn_attack;
  logic       hit_taken, jump_active;
  logic       move_enable, move_left, move_right, jump, attack_active, stun_active;
  logic [2:0] state;

  int errors  = 0;
  int checks  = 0;
  int tick_no = 0;
  bit scen_en = 1'b0;

  typedef struct {
    int         tick;
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  player_action_ctrl #(
    .DEB_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .SCEN         (SCEN),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_attack   (btn_attack),
    .hit_taken    (hit_taken),
    .jump_active  (jump_active),
    .move_enable  (move_enable),
    .move_left    (move_left),
    .move_right   (move_right),
    .jump         (jump),
    .attack_active(attack_active),
    .stun_active  (stun_active),
    .state        (state)
  );

  // Frame tick: one clk high out of every eight.
  initial begin
    int phase;
    phase = 0;
    SCEN  = 1'b0;
    forever begin
      @(negedge clk);
      phase = (phase == 7) ? 0 : phase + 1;
      SCEN  = scen_en && (phase == 0);
    end
  end

  task automatic push(input int t, input logic [2:0] st, input logic me, input logic ml,
                      input logic mr, input logic jp, input logic aa, input logic sa,
                      input string nm);
    exp_t e;
    e.tick = t;
    e.v    = {st, me, ml, mr, jp, aa, sa};
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [8:0] got;
    got = {state, move_enable, move_left, move_right, jump, attack_active, stun_active};
    checks++;
    if (got !== e.v) begin
      errors++;
      $display("FAIL %s tick=%0d got st=%0d me,ml,mr,jp,aa,sa=%b required st=%0d %b",
               e.nm, e.tick, got[8:6], got[5:0], e.v[8:6], e.v[5:0]);
    end else begin
      $display("ok   %s tick=%0d st=%0d me,ml,mr,jp,aa,sa=%b", e.nm, e.tick, got[8:6], got[5:0]);
    end
  endtask

  // Monitor: reset edges satisfy tick=-1 entries, SCEN edges satisfy tick_no entries.
  initial begin
    logic rs, sc;
    exp_t e;
    forever begin
      @(posedge clk);
      rs = reset;
      sc = SCEN;
      #1;
      if (rs) begin
        while (sb.size() != 0 && sb[0].tick == -1) begin
          e = sb.pop_front();
          compare(e);
        end
      end
      if (sc) begin
        tick_no++;
        while (sb.size() != 0 && sb[0].tick >= 0 && sb[0].tick <= tick_no) begin
          e = sb.pop_front();
          if (e.tick < tick_no) begin
            checks++;
            errors++;
            $display("FAIL %s missed: now tick %0d, required at tick %0d", e.nm, tick_no, e.tick);
          end else begin
            compare(e);
          end
        end
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (SCEN !== 1'b1);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic hit_pulse();
    hit_taken = 1'b1;
    @(negedge clk);
    hit_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset       = 1'b1;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    btn_up      = 1'b0;
    btn_attack  = 1'b0;
    hit_taken   = 1'b0;
    jump_active = 1'b0;
    push(-1, 3'd0, 0, 0, 0, 0, 0, 0, "reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    scen_en = 1'b1;
    wait_tick();

    // 3-clk glitch on right never reaches the debounced level
    k = tick_no;
    push(k + 1, 3'd0, 1, 0, 0, 0, 0, 0, "glitch_a");
    push(k + 2, 3'd0, 1, 0, 0, 0, 0, 0, "glitch_b");
    btn_right = 1'b1;
    repeat (3) @(negedge clk);
    btn_right = 1'b0;
    ticks(2);

    k = tick_no;
    push(k + 1, 3'd1, 1, 0, 1, 0, 0, 0, "right_walk");
    push(k + 2, 3'd1, 1, 0, 1, 0, 0, 0, "right_hold");
    btn_right = 1'b1;
    ticks(2);

    k = tick_no;
    push(k + 1, 3'd0, 1, 0, 0, 0, 0, 0, "both_idle");
    push(k + 2, 3'd0, 1, 0, 0, 0, 0, 0, "both_hold");
    btn_left = 1'b1;
    ticks(2);

    k = tick_no;
    push(k + 1, 3'd1, 1, 1, 0, 0, 0, 0, "left_walk");
    btn_right = 1'b0;
    ticks(1);

    k = tick_no;
    push(k + 1, 3'd0, 1, 0, 0, 0, 0, 0, "release_idle");
    btn_left = 1'b0;
    ticks(1);

    // Grounded jump: one-frame pulse despite the hold
    k = tick_no;
    push(k + 1, 3'd0, 1, 0, 0, 1, 0, 0, "jump_pulse");
    push(k + 2, 3'd0, 1, 0, 0, 0, 0, 0, "jump_cleared");
    push(k + 3, 3'd0, 1, 0, 0, 0, 0, 0, "jump_held");
    push(k + 4, 3'd0, 1, 0, 0, 0, 0, 0, "jump_release");
    btn_up = 1'b1;
    ticks(3);
    btn_up = 1'b0;
    ticks(1);

    // Airborne jump request is discarded
    k = tick_no;
    push(k + 1, 3'd0, 1, 0, 0, 0, 0, 0, "air_jump_a");
    push(k + 2, 3'd0, 1, 0, 0, 0, 0, 0, "air_jump_b");
    push(k + 3, 3'd0, 1, 0, 0, 0, 0, 0, "air_jump_c");
    push(k + 4, 3'd0, 1, 0, 0, 0, 0, 0, "air_jump_release");
    jump_active = 1'b1;
    btn_up      = 1'b1;
    ticks(3);
    btn_up = 1'b0;
    ticks(1);
    jump_active = 1'b0;

    // Attack: 6 frames ATTACK, 4 frames RECOVER, then IDLE
    k = tick_no;
    for (int i = 1; i <= 6; i++) push(k + i, 3'd2, 0, 0, 0, 0, 1, 0, "attack");
    for (int i = 7; i <= 10; i++) push(k + i, 3'd3, 0, 0, 0, 0, 0, 0, "recover");
    push(k + 11, 3'd0, 1, 0, 0, 0, 0, 0, "attack_done");
    btn_attack = 1'b1;
    ticks(1);
    btn_attack = 1'b0;
    ticks(10);

    // Hit at attack frame 2, second hit at stun frame 10: 11 + 12 stun frames
    k = tick_no;
    for (int i = 1; i <= 3; i++) push(k + i, 3'd2, 0, 0, 0, 0, 1, 0, "atk_before_hit");
    for (int i = 4; i <= 14; i++) push(k + i, 3'd4, 0, 0, 0, 0, 0, 1, "stun_first");
    for (int i = 15; i <= 26; i++) push(k + i, 3'd4, 0, 0, 0, 0, 0, 1, "stun_restart");
    push(k + 27, 3'd0, 1, 0, 0, 0, 0, 0, "stun_done");
    btn_attack = 1'b1;
    ticks(1);
    btn_attack = 1'b0;
    ticks(2);
    hit_pulse();
    ticks(11);
    hit_pulse();
    ticks(13);

    // Reset in the middle of a stun
    k = tick_no;
    push(k + 1, 3'd4, 0, 0, 0, 0, 0, 1, "stun_again_a");
    push(k + 2, 3'd4, 0, 0, 0, 0, 0, 1, "stun_again_b");
    hit_pulse();
    ticks(2);
    push(-1, 3'd0, 0, 0, 0, 0, 0, 0, "reset_mid_stun");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push(k + 3, 3'd0, 1, 0, 0, 0, 0, 0, "post_reset_idle");
    ticks(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
